// File: rtl/adc_pkg.sv
// Shared types and helpers for the flash ADC back-end.
// The optional min/max feature is enabled in the top by defining ADC_MINMAX_EN.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM
  } adc_state_e;

  // Comparator count for a given output resolution.
  function automatic int unsigned n_comp(input int unsigned bits);
    return (2 ** bits) - 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/therm2bin_enc.sv
// Combinational thermometer-to-binary encoder with 3-input majority bubble correction.
// The correction pads the code with a virtual 1 below bit 0 and a virtual 0 above the top bit.
module therm2bin_enc
  import adc_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic [n_comp(BITS)-1:0] i_therm,
  output logic [BITS-1:0]         o_code
);

  localparam int unsigned N = n_comp(BITS);

  logic [N+1:0]    w_ext;
  logic [N-1:0]    w_corr;
  logic [BITS-1:0] w_count;

  always_comb begin
    w_ext   = {1'b0, i_therm, 1'b1};
    w_corr  = '0;
    w_count = '0;
    for (int i = 0; i < N; i++) begin
      w_corr[i] = maj3(w_ext[i], w_ext[i+1], w_ext[i+2]);
    end
    // Ones-count tops out at N = 2**BITS-1, so BITS bits always suffice.
    for (int i = 0; i < N; i++) begin
      w_count = w_count + BITS'(w_corr[i]);
    end
  end

  assign o_code = w_count;

endmodule

// File: rtl/flash_adc_backend.sv
// Flash ADC back-end: synchronise, bubble-correct, encode, average and hand off results.
// Define ADC_MINMAX_EN to add per-window min_code/max_code outputs.
module flash_adc_backend
  import adc_pkg::*;
#(
  parameter int unsigned BITS          = 4,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [n_comp(BITS)-1:0] therm_in,
  output logic [BITS-1:0]         out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic                    busy
`ifdef ADC_MINMAX_EN
  ,
  output logic [BITS-1:0]         min_code,
  output logic [BITS-1:0]         max_code
`endif
);

  localparam int unsigned N       = n_comp(BITS);
  localparam int unsigned AccW    = BITS + AVG_LOG2;
  localparam int unsigned WinLen  = 2 ** AVG_LOG2;
  localparam int unsigned CntMax  = (SETTLE_CYCLES > WinLen) ? SETTLE_CYCLES : WinLen;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("flash_adc_backend: SETTLE_CYCLES must be >= 3");
  end

  logic [N-1:0]    r_sync1, r_sync2;
  logic [BITS-1:0] w_code, r_code;
  adc_state_e      r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [AccW-1:0] r_acc, w_acc_nxt, w_sum;
  logic [BITS-1:0] w_result;
  logic            w_win_end, w_load;
  logic [BITS-1:0] r_out_data;
  logic            r_out_valid, r_overrun, r_en_prev;

  therm2bin_enc #(
    .BITS (BITS)
  ) u_enc (
    .i_therm (r_sync2),
    .o_code  (w_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_code  <= '0;
    end else begin
      r_sync1 <= therm_in;
      r_sync2 <= r_sync1;
      r_code  <= w_code;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_win_end   = 1'b0;
    w_sum       = r_acc + AccW'(r_code);
    w_result    = w_sum[AccW-1:AVG_LOG2];
    if (!en) begin
      // Dropping enable abandons any partial window.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_acc_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end
        SETTLE: begin
          if (r_cnt == CntW'(SETTLE_CYCLES - 1)) begin
            w_state_nxt = ACCUM;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (r_cnt == CntW'(WinLen - 1)) begin
            w_win_end = 1'b1;
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
            w_acc_nxt = w_sum;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end
      endcase
    end
  end

  assign w_load = w_win_end & (~r_out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_en_prev   <= 1'b0;
    end else begin
      r_en_prev <= en;
      if (en && !r_en_prev) begin
        r_overrun <= 1'b0;
      end
      if (w_load) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else if (w_win_end) begin
        r_overrun <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ADC_MINMAX_EN
  logic [BITS-1:0] r_run_min, r_run_max, w_min_nxt, w_max_nxt;
  logic [BITS-1:0] r_min_code, r_max_code;

  always_comb begin
    w_min_nxt = (r_code < r_run_min) ? r_code : r_run_min;
    w_max_nxt = (r_code > r_run_max) ? r_code : r_run_max;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_min  <= '1;
      r_run_max  <= '0;
      r_min_code <= '0;
      r_max_code <= '0;
    end else begin
      if (en && (r_state == ACCUM) && !w_win_end) begin
        r_run_min <= w_min_nxt;
        r_run_max <= w_max_nxt;
      end else begin
        r_run_min <= '1;
        r_run_max <= '0;
      end
      if (w_load) begin
        r_min_code <= w_min_nxt;
        r_max_code <= w_max_nxt;
      end
    end
  end

  assign min_code = r_min_code;
  assign max_code = r_max_code;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule
